cache_sa_wb: RTL and testbench



---
 rtl/cache_sa_wb.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_cache_sa_wb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_sa_wb.sv
// N-way set-associative, write-back, write-allocate data cache, one word per line.
// A CPU access is captured in IDLE, resolved in LOOKUP, and a miss runs an
// optional victim writeback followed by a refill over a req/ack memory port.
// Replacement is true LRU using per-set age ranks; hit/miss counters saturate.
module cache_sa_wb #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 10,
  parameter int WAYS    = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              hit,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int AGE_W = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WB,
    REFILL
  } state_t;

  state_t state_reg, state_next;

  // Captured request
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [AGE_W-1:0]  victim_reg;

  wire [INDEX_W-1:0] idx     = addr_reg[INDEX_W-1:0];
  wire [TAG_W-1:0]   tag     = addr_reg[ADDR_W-1:INDEX_W];
  wire [INDEX_W-1:0] cpu_idx = cpu_addr[INDEX_W-1:0];

  // Per-line status bits and LRU ages live in flops so they can be reset
  logic [WAYS-1:0]  valid_reg [SETS];
  logic [WAYS-1:0]  dirty_reg [SETS];
  logic [AGE_W-1:0] age_reg   [SETS][WAYS];

  // Registered read of the tag/data rows for the captured index
  logic [TAG_W-1:0]  tag_rd  [WAYS];
  logic [DATA_W-1:0] data_rd [WAYS];
  logic [WAYS-1:0]   match;

  // Control strobes decided by the FSM
  logic              capture;
  logic              line_wr;
  logic              line_dirty;
  logic [DATA_W-1:0] line_data;
  logic              touch;
  logic              clr_dirty;
  logic [AGE_W-1:0]  way_sel;
  logic              ready_set;
  logic              hit_set;
  logic [DATA_W-1:0] rdata_val;
  logic              hit_inc;
  logic              miss_inc;
  logic              victim_ld;

  // Output registers
  logic              cpu_ready_reg;
  logic              hit_reg;
  logic [DATA_W-1:0] cpu_rdata_reg;
  logic [CNT_W-1:0]  hit_cnt_reg;
  logic [CNT_W-1:0]  miss_cnt_reg;

  // Per-way tag/data storage. Reads happen only on capture (IDLE) and writes
  // only in LOOKUP/WB/REFILL, so there is never a same-cycle read/write clash.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]  tag_mem  [SETS];
      logic [DATA_W-1:0] data_mem [SETS];
      logic [TAG_W-1:0]  tag_q;
      logic [DATA_W-1:0] data_q;

      // RAM write port and registered read port
      always_ff @(posedge clk) begin
        if (line_wr && (way_sel == AGE_W'(gi))) begin
          tag_mem[idx]  <= tag;
          data_mem[idx] <= line_data;
        end
        if (capture) begin
          tag_q  <= tag_mem[cpu_idx];
          data_q <= data_mem[cpu_idx];
        end
      end

      assign tag_rd[gi]  = tag_q;
      assign data_rd[gi] = data_q;
      assign match[gi]   = valid_reg[idx][gi] && (tag_q == tag);
    end
  endgenerate

  // Hit way encode and victim choice for the current set
  logic             hit_any;
  logic [AGE_W-1:0] hit_way;
  logic [AGE_W-1:0] inv_way;
  logic [AGE_W-1:0] lru_way;
  logic [AGE_W-1:0] vic_way;
  logic             vic_dirty;

  // Combinational way selection: lowest invalid way wins, else the oldest way
  always_comb begin
    hit_any = |match;
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (match[w]) hit_way = AGE_W'(w);
      if (age_reg[idx][w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_reg[idx][w]) inv_way = AGE_W'(w);
    end
    vic_way   = (&valid_reg[idx]) ? lru_way : inv_way;
    vic_dirty = valid_reg[idx][vic_way] && dirty_reg[idx][vic_way];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    line_wr    = 1'b0;
    line_dirty = 1'b0;
    line_data  = wdata_reg;
    touch      = 1'b0;
    clr_dirty  = 1'b0;
    way_sel    = victim_reg;
    ready_set  = 1'b0;
    hit_set    = 1'b0;
    rdata_val  = '0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    victim_ld  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cpu_req) begin
          capture    = 1'b1;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_any) begin
          way_sel    = hit_way;
          touch      = 1'b1;
          hit_inc    = 1'b1;
          ready_set  = 1'b1;
          hit_set    = 1'b1;
          rdata_val  = we_reg ? '0 : data_rd[hit_way];
          line_wr    = we_reg;
          line_dirty = 1'b1;
          state_next = IDLE;
        end else begin
          miss_inc  = 1'b1;
          victim_ld = 1'b1;
          way_sel   = vic_way;
          if (vic_dirty) begin
            state_next = WB;
          end else if (we_reg) begin
            line_wr    = 1'b1;
            line_dirty = 1'b1;
            touch      = 1'b1;
            ready_set  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = REFILL;
          end
        end
      end
      WB: begin
        if (mem_ack) begin
          clr_dirty = 1'b1;
          if (we_reg) begin
            line_wr    = 1'b1;
            line_dirty = 1'b1;
            touch      = 1'b1;
            ready_set  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = REFILL;
          end
        end
      end
      REFILL: begin
        if (mem_ack) begin
          line_wr    = 1'b1;
          line_dirty = 1'b0;
          line_data  = mem_rdata;
          touch      = 1'b1;
          ready_set  = 1'b1;
          rdata_val  = mem_rdata;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture and victim latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      victim_reg <= '0;
    end else begin
      if (capture) begin
        addr_reg  <= cpu_addr;
        we_reg    <= cpu_we;
        wdata_reg <= cpu_wdata;
      end
      if (victim_ld) victim_reg <= vic_way;
    end
  end

  // Valid/dirty bits and LRU ages; an install after writeback re-sets dirty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_reg[s][w] <= AGE_W'(w);
        end
      end
    end else begin
      if (clr_dirty) dirty_reg[idx][way_sel] <= 1'b0;
      if (line_wr) begin
        valid_reg[idx][way_sel] <= 1'b1;
        dirty_reg[idx][way_sel] <= line_dirty;
      end
      if (touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == way_sel)
            age_reg[idx][w] <= '0;
          else if (age_reg[idx][w] < age_reg[idx][way_sel])
            age_reg[idx][w] <= age_reg[idx][w] + 1'b1;
        end
      end
    end
  end

  // Registered CPU response and saturating statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ready_reg <= 1'b0;
      hit_reg       <= 1'b0;
      cpu_rdata_reg <= '0;
      hit_cnt_reg   <= '0;
      miss_cnt_reg  <= '0;
    end else begin
      cpu_ready_reg <= ready_set;
      hit_reg       <= hit_set;
      if (ready_set) cpu_rdata_reg <= rdata_val;
      if (hit_inc && (hit_cnt_reg != '1))   hit_cnt_reg  <= hit_cnt_reg + 1'b1;
      if (miss_inc && (miss_cnt_reg != '1)) miss_cnt_reg <= miss_cnt_reg + 1'b1;
    end
  end

  assign cpu_ready = cpu_ready_reg;
  assign hit       = hit_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign hit_cnt   = hit_cnt_reg;
  assign miss_cnt  = miss_cnt_reg;
  assign busy      = (state_reg != IDLE);
  assign mem_req   = (state_reg == WB) || (state_reg == REFILL);
  assign mem_we    = (state_reg == WB);
  assign mem_addr  = (state_reg == WB)     ? {tag_rd[victim_reg], idx} :
                     (state_reg == REFILL) ? addr_reg : '0;
  assign mem_wdata = (state_reg == WB) ? data_rd[victim_reg] : '0;

endmodule

// File: tb/tb_cache_sa_wb.sv
// Directed self-checking bench for cache_sa_wb (4-way, 1024 sets, 4-bit counters).
module tb_cache_sa_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [29:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        hit;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  hit_cnt;
  logic [3:0]  miss_cnt;

  cache_sa_wb #(.ADDR_W(30), .DATA_W(32), .INDEX_W(10), .WAYS(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .hit(hit), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observations from the most recent access
  int          rdy_cyc;
  logic [31:0] obs_rdata;
  logic        obs_hit;
  int          n_wb, n_rf, unstable;
  logic [29:0] wb_addr, rf_addr;
  logic [31:0] wb_data;

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one access, service the memory port, record what happened
  task automatic access(input logic we, input logic [29:0] addr, input logic [31:0] wd,
                        input int dly, input logic [31:0] rd);
    int cyc, wc;
    bit in_tx, done;
    logic [29:0] tx_addr;
    n_wb = 0; n_rf = 0; unstable = 0; rdy_cyc = 0; obs_hit = 1'b0; obs_rdata = '0;
    cyc = 0; wc = 0; in_tx = 0; done = 0; tx_addr = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) cpu_req = 1'b0;
      if (mem_ack) begin mem_ack = 1'b0; in_tx = 0; end
      if (cpu_ready) begin
        done = 1; rdy_cyc = cyc; obs_rdata = cpu_rdata; obs_hit = hit;
      end else if (mem_req) begin
        if (!in_tx) begin
          in_tx = 1; wc = 0; tx_addr = mem_addr;
          if (mem_we) begin n_wb++; wb_addr = mem_addr; wb_data = mem_wdata; end
          else begin n_rf++; rf_addr = mem_addr; end
        end else if (mem_addr !== tx_addr) unstable++;
        if (wc == dly) begin mem_ack = 1'b1; mem_rdata = rd; end
        else wc++;
      end
    end
    tests++;
    if (!done || unstable != 0) begin
      fails++;
      $display("FAIL access_%h: done=%0d unstable=%0d, required done=1 unstable=0", addr, done, unstable);
    end
    $display("[TB] access we=%0d addr=%h -> cyc=%0d hit=%0d rdata=%h wb=%0d rf=%0d",
             we, addr, rdy_cyc, obs_hit, obs_rdata, n_wb, n_rf);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", cpu_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    tests++; if (hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin fails++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    tests++; if (cpu_rdata !== 32'd0 || hit !== 1'b0) begin fails++; $display("FAIL rst_rdata: got %h hit %b want 0", cpu_rdata, hit); end
  endtask

  task automatic test_read_miss_hit();
    access(1'b0, 30'h405, 32'h0, 3, 32'hDEADBEEF);
    tests++; if (n_rf !== 1 || rf_addr !== 30'h405 || n_wb !== 0) begin fails++; $display("FAIL rmiss_mem: rf=%0d addr=%h wb=%0d want 1/405/0", n_rf, rf_addr, n_wb); end
    tests++; if (obs_rdata !== 32'hDEADBEEF || obs_hit !== 1'b0) begin fails++; $display("FAIL rmiss_data: got %h hit %b want deadbeef 0", obs_rdata, obs_hit); end
    tests++; if (miss_cnt !== 4'd1) begin fails++; $display("FAIL rmiss_cnt: got %0d want 1", miss_cnt); end
    access(1'b0, 30'h405, 32'h0, 0, 32'h0);
    tests++; if (rdy_cyc !== 2 || obs_hit !== 1'b1 || n_rf !== 0) begin fails++; $display("FAIL rhit: cyc=%0d hit=%b rf=%0d want 2/1/0", rdy_cyc, obs_hit, n_rf); end
    tests++; if (obs_rdata !== 32'hDEADBEEF || hit_cnt !== 4'd1) begin fails++; $display("FAIL rhit_data: got %h cnt %0d want deadbeef 1", obs_rdata, hit_cnt); end
  endtask

  task automatic test_write_miss();
    access(1'b1, 30'h805, 32'h12345678, 0, 32'h0);
    tests++; if (n_rf !== 0 || n_wb !== 0 || rdy_cyc !== 2 || obs_hit !== 1'b0) begin fails++; $display("FAIL wmiss: rf=%0d wb=%0d cyc=%0d hit=%b want 0/0/2/0", n_rf, n_wb, rdy_cyc, obs_hit); end
    tests++; if (miss_cnt !== 4'd2) begin fails++; $display("FAIL wmiss_cnt: got %0d want 2", miss_cnt); end
    access(1'b0, 30'h805, 32'h0, 0, 32'h0);
    tests++; if (obs_hit !== 1'b1 || obs_rdata !== 32'h12345678) begin fails++; $display("FAIL wmiss_readback: got %h hit %b want 12345678 1", obs_rdata, obs_hit); end
  endtask

  task automatic test_writeback();
    access(1'b1, 30'h405, 32'd1, 0, 32'h0);
    access(1'b1, 30'h805, 32'd2, 0, 32'h0);
    access(1'b1, 30'hC05, 32'd3, 0, 32'h0);
    access(1'b1, 30'h1005, 32'd4, 0, 32'h0);
    tests++; if (n_wb !== 0 || n_rf !== 0) begin fails++; $display("FAIL fill_set: wb=%0d rf=%0d want 0/0", n_wb, n_rf); end
    access(1'b0, 30'h805, 32'h0, 0, 32'h0);
    access(1'b0, 30'hC05, 32'h0, 0, 32'h0);
    tests++; if (obs_hit !== 1'b1 || obs_rdata !== 32'd3) begin fails++; $display("FAIL ld_c05: got %h hit %b want 3 1", obs_rdata, obs_hit); end
    access(1'b0, 30'h1005, 32'h0, 0, 32'h0);
    access(1'b0, 30'h1405, 32'h0, 1, 32'h55AA55AA);
    tests++; if (n_wb !== 1 || wb_addr !== 30'h405 || wb_data !== 32'd1) begin fails++; $display("FAIL wb_victim: wb=%0d addr=%h data=%h want 1/405/1", n_wb, wb_addr, wb_data); end
    tests++; if (n_rf !== 1 || rf_addr !== 30'h1405 || obs_rdata !== 32'h55AA55AA) begin fails++; $display("FAIL wb_refill: rf=%0d addr=%h data=%h want 1/1405/55aa55aa", n_rf, rf_addr, obs_rdata); end
    access(1'b0, 30'h405, 32'h0, 0, 32'h77);
    tests++; if (obs_hit !== 1'b0 || n_wb !== 1 || wb_addr !== 30'h805 || wb_data !== 32'd2) begin fails++; $display("FAIL reload_405: hit=%b wb=%0d addr=%h data=%h want 0/1/805/2", obs_hit, n_wb, wb_addr, wb_data); end
    tests++; if (hit_cnt !== 4'd7 || miss_cnt !== 4'd6) begin fails++; $display("FAIL wb_cnts: got %0d/%0d want 7/6", hit_cnt, miss_cnt); end
  endtask

  task automatic test_clean_evict();
    do_reset();
    access(1'b0, 30'h405, 32'h0, 0, 32'hA0);
    access(1'b0, 30'h805, 32'h0, 0, 32'hA1);
    access(1'b0, 30'hC05, 32'h0, 0, 32'hA2);
    access(1'b0, 30'h1005, 32'h0, 0, 32'hA3);
    access(1'b0, 30'h405, 32'h0, 0, 32'h0);
    tests++; if (obs_hit !== 1'b1 || obs_rdata !== 32'hA0) begin fails++; $display("FAIL ce_hit405: got %h hit %b want a0 1", obs_rdata, obs_hit); end
    access(1'b0, 30'h1405, 32'h0, 2, 32'hA4);
    tests++; if (n_wb !== 0 || n_rf !== 1 || rf_addr !== 30'h1405) begin fails++; $display("FAIL ce_refill: wb=%0d rf=%0d addr=%h want 0/1/1405", n_wb, n_rf, rf_addr); end
    access(1'b0, 30'h405, 32'h0, 0, 32'h0);
    tests++; if (obs_hit !== 1'b1 || obs_rdata !== 32'hA0) begin fails++; $display("FAIL ce_keep405: got %h hit %b want a0 1", obs_rdata, obs_hit); end
    access(1'b0, 30'h805, 32'h0, 0, 32'hA5);
    tests++; if (obs_hit !== 1'b0 || n_wb !== 0 || obs_rdata !== 32'hA5) begin fails++; $display("FAIL ce_evicted805: hit=%b wb=%0d data=%h want 0/0/a5", obs_hit, n_wb, obs_rdata); end
    access(1'b0, 30'h1005, 32'h0, 0, 32'h0);
    tests++; if (obs_hit !== 1'b1 || obs_rdata !== 32'hA3) begin fails++; $display("FAIL ce_keep1005: got %h hit %b want a3 1", obs_rdata, obs_hit); end
  endtask

  task automatic test_reset_refill();
    bit seen;
    seen = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h2405;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we) seen = 1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL rr_refill_start: mem_req never rose"); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (mem_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rr_drop: mem_req=%b busy=%b want 0/0", mem_req, busy); end
    tests++; if (hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin fails++; $display("FAIL rr_cnt: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 30'h405, 32'h0, 0, 32'h0BADF00D);
    tests++; if (obs_hit !== 1'b0 || n_rf !== 1 || obs_rdata !== 32'h0BADF00D) begin fails++; $display("FAIL rr_miss405: hit=%b rf=%0d data=%h want 0/1/0badf00d", obs_hit, n_rf, obs_rdata); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      access(1'b0, 30'h405, 32'h0, 0, 32'h0);
      tests++; if (obs_hit !== 1'b1 || obs_rdata !== 32'h0BADF00D) begin fails++; $display("FAIL sat_hit%0d: hit=%b data=%h want 1/0badf00d", i, obs_hit, obs_rdata); end
      if (i == 14) begin
        tests++; if (hit_cnt !== 4'd15) begin fails++; $display("FAIL sat_reach: got %0d want 15", hit_cnt); end
      end
    end
    tests++; if (hit_cnt !== 4'd15 || miss_cnt !== 4'd1) begin fails++; $display("FAIL sat_hold: got %0d/%0d want 15/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [4:1] rdy;
    logic       hit4, busy1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h405;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      rdy[c] = cpu_ready;
      if (c == 1) busy1 = busy;
      if (c == 4) hit4 = hit;
      if (c == 3) cpu_req = 1'b0;
    end
    $display("[TB] back_to_back ready=%b hit4=%b", rdy, hit4);
    tests++; if (rdy !== 4'b1010) begin fails++; $display("FAIL b2b_ready: got %b want 1010", rdy); end
    tests++; if (hit4 !== 1'b1 || busy1 !== 1'b1) begin fails++; $display("FAIL b2b_hit: hit=%b busy=%b want 1/1", hit4, busy1); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_miss();
    test_writeback();
    test_clean_evict();
    test_reset_refill();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
